// File: rtl/song_ctrl_pkg.sv
// Shared state encoding and fixed box/background geometry for the song frame sequencer.
package song_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEF_ADDR,
        DEF_LOAD,
        DEF_WRITE,
        WAIT_BEAT,
        SHIFT,
        SCORE_CHK,
        SCORE_ADD,
        BOX_START,
        BOX_SETTLE,
        PIX_SETUP,
        PIX_WRITE,
        STEP_END,
        DONE
    } state_t;

    localparam logic [3:0] NUM_BOXES      = 4'd12;
    localparam logic [3:0] BOX_FIRST      = 4'd1;
    localparam int         DEF_CYC        = 3;
    localparam int         BOX_SETTLE_CYC = 2;

endpackage

// File: rtl/song_frame_controller_beat_timer.sv
// Free-running beat counter: one-cycle tick every BEAT_CYCLES enabled cycles.
// Tick is combinational from the count; clear holds the count at zero.
module beat_timer #(
    parameter int BEAT_CYCLES = 12500000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/song_frame_controller.sv
// Song sequencer: draws the background once, then per beat shifts/scores and redraws twelve note boxes.
// Beats arriving while boxes are drawn are remembered one deep; further beats are dropped.
module song_frame_controller #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int SONG_STEPS  = 112,
    parameter int GRID_W      = 240,
    parameter int GRID_H      = 180,
    parameter int BOX_W       = 60,
    parameter int BOX_H       = 60,
    parameter int PIX_LAT     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        shiftSong,
    output logic        changeScore,
    output logic        addScore,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        writeToScreen,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic        songDone,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic        plot,
    output logic        busy
);

    import song_ctrl_pkg::*;

    localparam logic [7:0]  GX_LAST     = 8'(GRID_W - 1);
    localparam logic [7:0]  GY_LAST     = 8'(GRID_H - 1);
    localparam logic [7:0]  PX_LAST     = 8'(BOX_W - 1);
    localparam logic [6:0]  PY_LAST     = 7'(BOX_H - 1);
    localparam logic [15:0] STEP_LAST   = 16'(SONG_STEPS - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(BOX_SETTLE_CYC - 1);
    localparam logic [7:0]  SETUP_LAST  = 8'(PIX_LAT - 1);

    state_t      state, state_nxt;
    logic [7:0]  gx, gy, px, dwell;
    logic [6:0]  py;
    logic [3:0]  box;
    logic [15:0] step;
    logic        timer_run, pending, tick;
    logic        last_grid, last_pix, last_box, last_step;

    assign last_grid = (gx == GX_LAST) && (gy == GY_LAST);
    assign last_pix  = (px == PX_LAST) && (py == PY_LAST);
    assign last_box  = (box == NUM_BOXES);
    assign last_step = (step == STEP_LAST);

    assign gridCounter = {gx, gy};
    assign boxCounter  = box;
    assign pixelCount  = {px, py};

    beat_timer #(
        .BEAT_CYCLES(BEAT_CYCLES)
    ) u_beat_timer (
        .clock (clock),
        .reset (reset),
        .enable(timer_run),
        .clear (!timer_run),
        .tick  (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = DEF_ADDR;
            DEF_ADDR:   state_nxt = DEF_LOAD;
            DEF_LOAD:   state_nxt = DEF_WRITE;
            DEF_WRITE:  state_nxt = last_grid ? WAIT_BEAT : DEF_ADDR;
            WAIT_BEAT:  if (tick || pending) state_nxt = SHIFT;
            SHIFT:      state_nxt = SCORE_CHK;
            SCORE_CHK:  state_nxt = SCORE_ADD;
            SCORE_ADD:  state_nxt = BOX_START;
            BOX_START:  state_nxt = BOX_SETTLE;
            BOX_SETTLE: if (dwell == SETTLE_LAST) state_nxt = PIX_SETUP;
            PIX_SETUP:  if (dwell == SETUP_LAST) state_nxt = PIX_WRITE;
            PIX_WRITE: begin
                if (!last_pix)      state_nxt = PIX_SETUP;
                else if (!last_box) state_nxt = BOX_START;
                else                state_nxt = STEP_END;
            end
            STEP_END:   state_nxt = last_step ? DONE : WAIT_BEAT;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shiftSong        = 1'b0;
        changeScore      = 1'b0;
        addScore         = 1'b0;
        loadStartAddress = 1'b0;
        loadX            = 1'b0;
        loadY            = 1'b0;
        writeToScreen    = 1'b0;
        loadDefault      = 1'b0;
        writeDefault     = 1'b0;
        songDone         = 1'b0;
        busy             = (state != IDLE);
        case (state)
            DEF_LOAD:  loadDefault      = 1'b1;
            DEF_WRITE: writeDefault     = 1'b1;
            SHIFT:     shiftSong        = 1'b1;
            SCORE_CHK: changeScore      = 1'b1;
            SCORE_ADD: addScore         = 1'b1;
            BOX_START: loadStartAddress = 1'b1;
            PIX_SETUP: begin
                loadX = 1'b1;
                loadY = 1'b1;
            end
            PIX_WRITE: writeToScreen    = 1'b1;
            DONE:      songDone         = 1'b1;
            default:   ;
        endcase
    end

    // Counters advance on the last cycle of the pixel they address, so each value stays put for its whole window.
    always_ff @(posedge clock) begin
        if (reset) begin
            gx        <= '0;
            gy        <= '0;
            px        <= '0;
            py        <= '0;
            box       <= '0;
            step      <= '0;
            dwell     <= '0;
            timer_run <= 1'b0;
            pending   <= 1'b0;
            plot      <= 1'b0;
        end else begin
            dwell <= (state_nxt != state) ? '0 : dwell + 8'd1;
            plot  <= writeToScreen || writeDefault;

            if (state == DEF_WRITE) begin
                if (gy == GY_LAST) begin
                    gy <= '0;
                    gx <= (gx == GX_LAST) ? '0 : gx + 8'd1;
                end else begin
                    gy <= gy + 8'd1;
                end
            end

            if (state == SCORE_ADD) begin
                box <= BOX_FIRST;
            end else if (state == PIX_WRITE) begin
                if (py == PY_LAST) begin
                    py <= '0;
                    px <= (px == PX_LAST) ? '0 : px + 8'd1;
                end else begin
                    py <= py + 7'd1;
                end
                if (last_pix) box <= last_box ? '0 : box + 4'd1;
            end

            if (state == IDLE) begin
                step <= '0;
            end else if (state == STEP_END && !last_step) begin
                step <= step + 16'd1;
            end

            if (state == IDLE || state == DONE) begin
                timer_run <= 1'b0;
            end else if (state == DEF_WRITE && last_grid) begin
                timer_run <= 1'b1;
            end

            // A tick landing on the same cycle a latched beat is consumed stays latched.
            if (state == IDLE) begin
                pending <= 1'b0;
            end else if (state == WAIT_BEAT) begin
                pending <= pending && tick;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_song_frame_controller.sv
// Two controllers (slow and fast beat) checked every cycle against a song-level sequence model.
module tb_song_frame_controller;

    localparam int STEPS = 3, GW = 4, GH = 3, BW = 2, BH = 2, PIX_LAT = 3;
    localparam int BC_A = 50, BC_B = 10;

    typedef struct packed {
        logic shift, chg, add, lsa, lxy, wts, ldef, wdef, done, busy;
        logic [15:0] grid;
        logic [3:0]  box;
        logic [14:0] pix;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic shiftSong_a, changeScore_a, addScore_a, loadStartAddress_a, loadX_a, loadY_a;
    logic writeToScreen_a, loadDefault_a, writeDefault_a, songDone_a, plot_a, busy_a;
    logic [15:0] gridCounter_a;
    logic [3:0]  boxCounter_a;
    logic [14:0] pixelCount_a;
    logic shiftSong_b, changeScore_b, addScore_b, loadStartAddress_b, loadX_b, loadY_b;
    logic writeToScreen_b, loadDefault_b, writeDefault_b, songDone_b, plot_b, busy_b;
    logic [15:0] gridCounter_b;
    logic [3:0]  boxCounter_b;
    logic [14:0] pixelCount_b;

    song_frame_controller #(.BEAT_CYCLES(BC_A), .SONG_STEPS(STEPS), .GRID_W(GW), .GRID_H(GH),
                            .BOX_W(BW), .BOX_H(BH), .PIX_LAT(PIX_LAT)) dut_a (
        .clock(clock), .reset(reset), .start(start),
        .shiftSong(shiftSong_a), .changeScore(changeScore_a), .addScore(addScore_a),
        .loadStartAddress(loadStartAddress_a), .loadX(loadX_a), .loadY(loadY_a),
        .writeToScreen(writeToScreen_a), .loadDefault(loadDefault_a), .writeDefault(writeDefault_a),
        .songDone(songDone_a), .gridCounter(gridCounter_a), .boxCounter(boxCounter_a),
        .pixelCount(pixelCount_a), .plot(plot_a), .busy(busy_a));

    song_frame_controller #(.BEAT_CYCLES(BC_B), .SONG_STEPS(STEPS), .GRID_W(GW), .GRID_H(GH),
                            .BOX_W(BW), .BOX_H(BH), .PIX_LAT(PIX_LAT)) dut_b (
        .clock(clock), .reset(reset), .start(start),
        .shiftSong(shiftSong_b), .changeScore(changeScore_b), .addScore(addScore_b),
        .loadStartAddress(loadStartAddress_b), .loadX(loadX_b), .loadY(loadY_b),
        .writeToScreen(writeToScreen_b), .loadDefault(loadDefault_b), .writeDefault(writeDefault_b),
        .songDone(songDone_b), .gridCounter(gridCounter_b), .boxCounter(boxCounter_b),
        .pixelCount(pixelCount_b), .plot(plot_b), .busy(busy_b));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    logic [1:0] prev_plot = 2'b00;
    exp_t q0[$], q1[$];

    // Model state: cycle index within the song being generated, and beat bookkeeping.
    int g_cyc, g_run, g_bc, g_which;
    logic g_pend;

    function automatic logic tick_at(input int c);
        return (g_run >= 0) && (c >= g_run) && (((c - g_run) % g_bc) == g_bc - 1);
    endfunction

    task automatic push_raw(input int which, input exp_t e);
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic put(input exp_t e, input bit is_wait);
        if (!is_wait) g_pend = g_pend | tick_at(g_cyc);
        push_raw(g_which, e);
        g_cyc++;
    endtask

    task automatic gen_song(input int which, input int bc);
        exp_t e;
        logic go;
        g_which = which; g_bc = bc; g_cyc = 0; g_run = -1; g_pend = 1'b0;
        e = '0;
        e.busy = 1'b1;
        for (int x = 0; x < GW; x++) begin
            for (int y = 0; y < GH; y++) begin
                e.grid = {8'(x), 8'(y)};
                put(e, 1'b0);
                e.ldef = 1'b1; put(e, 1'b0); e.ldef = 1'b0;
                e.wdef = 1'b1; put(e, 1'b0); e.wdef = 1'b0;
            end
        end
        e.grid = '0;
        g_run = g_cyc;
        for (int s = 0; s < STEPS; s++) begin
            // Wait for a beat: either one remembered from the previous draw or a fresh tick.
            do begin
                go = g_pend | tick_at(g_cyc);
                if (go) g_pend = g_pend & tick_at(g_cyc);
                put(e, 1'b1);
            end while (!go);
            e.shift = 1'b1; put(e, 1'b0); e.shift = 1'b0;
            e.chg   = 1'b1; put(e, 1'b0); e.chg   = 1'b0;
            e.add   = 1'b1; put(e, 1'b0); e.add   = 1'b0;
            for (int b = 1; b <= 12; b++) begin
                e.box = 4'(b);
                e.pix = '0;
                e.lsa = 1'b1; put(e, 1'b0); e.lsa = 1'b0;
                put(e, 1'b0); put(e, 1'b0);
                for (int x = 0; x < BW; x++) begin
                    for (int y = 0; y < BH; y++) begin
                        e.pix = {8'(x), 7'(y)};
                        e.lxy = 1'b1;
                        repeat (PIX_LAT) put(e, 1'b0);
                        e.lxy = 1'b0;
                        e.wts = 1'b1; put(e, 1'b0); e.wts = 1'b0;
                    end
                end
            end
            e.box = '0;
            e.pix = '0;
            put(e, 1'b0);
        end
        e.done = 1'b1;
        put(e, 1'b0);
    endtask

    function automatic logic [45:0] pack(input exp_t e);
        return {e.shift, e.chg, e.add, e.lsa, e.lxy, e.lxy, e.wts, e.ldef, e.wdef, e.done, e.busy,
                e.grid, e.box, e.pix};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cmp(input int w, input logic [45:0] act, input logic act_plot);
        exp_t e;
        e = '0;
        if (w == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        checks++;
        if (act !== pack(e)) begin
            failures++;
            $display("FAIL outputs dut%0d t=%0t: got %h expected %h", w, $time, act, pack(e));
        end
        checks++;
        if (act_plot !== prev_plot[w]) begin
            failures++;
            $display("FAIL plot dut%0d t=%0t: got %b expected %b", w, $time, act_plot, prev_plot[w]);
        end
        prev_plot[w] = e.wts | e.wdef;
    endtask

    int lx_run = 0;
    logic [14:0] lx_pix = '0;

    always @(negedge clock) begin
        if (chk_en) begin
            cmp(0, {shiftSong_a, changeScore_a, addScore_a, loadStartAddress_a, loadX_a, loadY_a,
                    writeToScreen_a, loadDefault_a, writeDefault_a, songDone_a, busy_a,
                    gridCounter_a, boxCounter_a, pixelCount_a}, plot_a);
            cmp(1, {shiftSong_b, changeScore_b, addScore_b, loadStartAddress_b, loadX_b, loadY_b,
                    writeToScreen_b, loadDefault_b, writeDefault_b, songDone_b, busy_b,
                    gridCounter_b, boxCounter_b, pixelCount_b}, plot_b);
            if (loadX_a) begin
                if (lx_run > 0) begin
                    checks++;
                    if (pixelCount_a !== lx_pix) begin
                        failures++;
                        $display("FAIL pix_hold: got %h expected %h", pixelCount_a, lx_pix);
                    end
                end
                lx_pix = pixelCount_a;
                lx_run++;
            end else if (writeToScreen_a) begin
                checks++;
                if (lx_run != PIX_LAT || pixelCount_a !== lx_pix) begin
                    failures++;
                    $display("FAIL setup_window: got run %0d pix %h expected run %0d pix %h",
                             lx_run, pixelCount_a, PIX_LAT, lx_pix);
                end
                lx_run = 0;
            end else begin
                lx_run = 0;
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int n, k, cyc, rises;
        logic prev_lx;
        repeat (3) step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        repeat ($urandom_range(3, 10)) step();

        // First song, with stray start pulses while busy.
        start = 1'b1;
        gen_song(0, BC_A);
        gen_song(1, BC_B);
        chk("model_len_a", q0.size(), 785);
        chk("model_len_b", q1.size(), 745);
        chk("model_last_grid", int'(q0[35].grid), 16'h0302);
        chk("model_first_box_write", int'(q0[95].wts) * 16 + int'(q0[95].box), 17);
        chk("model_done_at", int'(q0[784].done), 1);
        n = 0;
        for (int i = 0; i < q0.size(); i++) n += int'(q0[i].ldef);
        chk("model_ldef_count", n, 12);
        n = 0;
        for (int i = 0; i < q0.size(); i++) n += int'(q0[i].wts);
        chk("model_wts_count", n, 144);
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < 2000) begin
            step();
            start = (q0.size() > 5 && q1.size() > 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc++;
        end
        chk("song1_timeout", cyc < 2000 ? 0 : 1, 0);
        repeat (4) step();

        // Start held across DONE: each controller restarts after one idle cycle.
        start = 1'b1;
        gen_song(0, BC_A); push_raw(0, '0); gen_song(0, BC_A);
        gen_song(1, BC_B); push_raw(1, '0); gen_song(1, BC_B);
        cyc = 0;
        while (q0.size() > 784 && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("restart_timeout", cyc < 2000 ? 0 : 1, 0);
        start = 1'b0;

        // Reset during a pixel setup of the second song aborts without songDone.
        k = $urandom_range(1, 100);
        rises = 0;
        prev_lx = 1'b0;
        cyc = 0;
        while (rises < k && cyc < 3000) begin
            step();
            if (loadX_a && !prev_lx) rises++;
            prev_lx = loadX_a;
            cyc++;
        end
        chk("reset_point_timeout", cyc < 3000 ? 0 : 1, 0);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        prev_plot = 2'b00;
        step();
        reset = 1'b0;
        repeat (20) step();

        // A clean song after the abort.
        start = 1'b1;
        gen_song(0, BC_A);
        gen_song(1, BC_B);
        step();
        start = 1'b0;
        cyc = 0;
        while ((q0.size() > 0 || q1.size() > 0) && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("song3_timeout", cyc < 2000 ? 0 : 1, 0);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
